// File: rtl/rnbip_pkg.sv
// Shared RNBIP opcode classes, sequencer state encoding and decode helpers.
// Reused by the pipeline sequencer and the instruction decoder.
package rnbip_pkg;

   localparam logic [7:0] OP_NOP = 8'h00;
   localparam logic [4:0] OP_LDA = 5'b01110;
   localparam logic [4:0] OP_POP = 5'b01111;
   localparam logic [3:0] OP_IO  = 4'b1111;

   // Sequencer states: a plain 2-bit type so legacy netlists can match encodings
   typedef logic [1:0] state_t;
   localparam state_t ST_RUN     = 2'd0;
   localparam state_t ST_FLUSH   = 2'd1;
   localparam state_t ST_IO_WAIT = 2'd2;
   localparam state_t ST_IO_DONE = 2'd3;

   function automatic logic is_load_rn(input logic [7:0] op);
      return ((op[7:3] == OP_LDA) && (op[2:0] != 3'b000)) || (op[7:3] == OP_POP);
   endfunction

   function automatic logic is_io(input logic [7:0] op);
      return op[7:4] == OP_IO;
   endfunction

   function automatic logic is_rn_reader(input logic [7:0] op);
      logic reader;
      reader = 1'b0;
      if ((op[7:3] == 5'b00100) || (op[7:3] == 5'b01000) ||
          (op[7:3] == 5'b01010) || (op[7:3] == 5'b01101))
         reader = 1'b1;
      else if (op[7:3] == 5'b01100)
         reader = (op[2:0] != 3'b000);
      // Register ALU group 1000..1110; 1111 is the port I/O class
      else if (op[7] && !op[3] && (op[7:4] != OP_IO))
         reader = 1'b1;
      return reader;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Port I/O handshake between the pipeline sequencer and the port block.
interface pipe_hazard_ctrl_if;
   logic       io_req;
   logic       io_we;
   logic [2:0] io_port;
   logic       io_ack;
   logic [7:0] io_rdata;

   modport master (output io_req, io_we, io_port, input io_ack, io_rdata);
   modport slave  (input io_req, io_we, io_port, output io_ack, io_rdata);
endinterface

// File: rtl/pipe_hazard_ctrl_io_timer.sv
// Up-counter for the port I/O wait; clear loads zero, expiry at IO_TIMEOUT-1.
module pipe_io_timer #(
   parameter int IO_TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int TW = $clog2(IO_TIMEOUT);
   localparam logic [TW-1:0] LAST = TW'(IO_TIMEOUT - 1);

   logic [TW-1:0] count;

   // Holds at the last value so expiry stays asserted until the owner clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && (count != LAST))
         count <= count + TW'(1);
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// RNBIP pipeline sequencer: load-use stall, taken-branch squash, port I/O
// handshake with timeout, and a saturating stall-cycle counter.
module pipe_hazard_ctrl
   import rnbip_pkg::*;
#(
   parameter int IO_TIMEOUT = 64,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       id_opcode,
   input  logic             id_valid,
   input  logic [7:0]       ex_opcode,
   input  logic             ex_valid,
   input  logic             ex_branch_taken,
   pipe_hazard_ctrl_if.master io,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [7:0]       in_data,
   output logic             io_timeout,
   output logic [CNT_W-1:0] stall_cycles
);

   state_t state, next_state;
   logic   branch_hit, load_use, io_hit, timer_expired;

   always_comb begin
      branch_hit = ex_valid && ex_branch_taken;
      load_use   = ex_valid && is_load_rn(ex_opcode) &&
                   id_valid && is_rn_reader(id_opcode) &&
                   (id_opcode[2:0] == ex_opcode[2:0]);
      io_hit     = id_valid && is_io(id_opcode);
   end

   // Controls are combinational so they act on the edge that detects the hazard
   always_comb begin
      next_state  = state;
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      case (state)
         ST_RUN: begin
            if (branch_hit) begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               next_state  = ST_FLUSH;
            end else if (load_use) begin
               pc_stall    = 1'b1;
               ifid_stall  = 1'b1;
               idex_bubble = 1'b1;
            end else if (io_hit) begin
               pc_stall    = 1'b1;
               ifid_stall  = 1'b1;
               idex_bubble = 1'b1;
               next_state  = ST_IO_WAIT;
            end
         end
         ST_FLUSH: begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            next_state  = ST_RUN;
         end
         ST_IO_WAIT: begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
            if (io.io_ack || timer_expired)
               next_state = ST_IO_DONE;
         end
         default: next_state = ST_RUN;
      endcase
      if (!rst_n) begin
         pc_stall    = 1'b0;
         ifid_stall  = 1'b0;
         ifid_flush  = 1'b0;
         idex_bubble = 1'b0;
      end
   end

   pipe_io_timer #(.IO_TIMEOUT(IO_TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state != ST_IO_WAIT),
      .enable  (state == ST_IO_WAIT),
      .expired (timer_expired)
   );

   // An ack on the expiry cycle wins: data is taken and no timeout is flagged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_RUN;
         io.io_req  <= 1'b0;
         io.io_we   <= 1'b0;
         io.io_port <= 3'd0;
         in_data    <= 8'h00;
         io_timeout <= 1'b0;
      end else begin
         state      <= next_state;
         io.io_req  <= (next_state == ST_IO_WAIT);
         io_timeout <= (state == ST_IO_WAIT) && !io.io_ack && timer_expired;
         if ((state == ST_RUN) && (next_state == ST_IO_WAIT)) begin
            io.io_we   <= id_opcode[3];
            io.io_port <= id_opcode[2:0];
         end
         if ((state == ST_IO_WAIT) && io.io_ack && !io.io_we)
            in_data <= io.io_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cycles <= '0;
      else if (pc_stall && (stall_cycles != '1))
         stall_cycles <= stall_cycles + CNT_W'(1);
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a short I/O timeout and a 4-bit stall counter.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] id_opcode, ex_opcode;
   logic       id_valid, ex_valid, ex_branch_taken;
   logic       pc_stall, ifid_stall, ifid_flush, idex_bubble;
   logic [7:0] in_data;
   logic       io_timeout;
   logic [3:0] stall_cycles;

   int n_cmp = 0;
   int n_err = 0;

   pipe_hazard_ctrl_if io_bus ();

   pipe_hazard_ctrl #(.IO_TIMEOUT(4), .CNT_W(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_opcode       (id_opcode),
      .id_valid        (id_valid),
      .ex_opcode       (ex_opcode),
      .ex_valid        (ex_valid),
      .ex_branch_taken (ex_branch_taken),
      .io              (io_bus),
      .pc_stall        (pc_stall),
      .ifid_stall      (ifid_stall),
      .ifid_flush      (ifid_flush),
      .idex_bubble     (idex_bubble),
      .in_data         (in_data),
      .io_timeout      (io_timeout),
      .stall_cycles    (stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected) else begin
         n_err++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Control vector order: {pc_stall, ifid_stall, ifid_flush, idex_bubble}
   task automatic check_ctrl(input string tag, input logic [3:0] expected);
      check(tag, {28'd0, pc_stall, ifid_stall, ifid_flush, idex_bubble}, {28'd0, expected});
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n           = 1'b0;
      id_opcode       = 8'h00;
      id_valid        = 1'b0;
      ex_opcode       = 8'h00;
      ex_valid        = 1'b0;
      ex_branch_taken = 1'b0;
      io_bus.io_ack   = 1'b0;
      io_bus.io_rdata = 8'h00;
      #1;
      check_ctrl("reset_ctrl", 4'b0000);
      check("reset_io_req", io_bus.io_req, 0);
      check("reset_io_port", io_bus.io_port, 0);
      check("reset_in_data", in_data, 0);
      check("reset_stall_cycles", stall_cycles, 0);
      tick;
      tick;
      rst_n = 1'b1;

      $display("[TB] load-use");
      ex_opcode = 8'h71; ex_valid = 1'b1; id_opcode = 8'h81; id_valid = 1'b1;
      #1 check_ctrl("lu_stall", 4'b1101);
      tick;
      ex_valid = 1'b0;
      #1 check_ctrl("lu_bubble_clears", 4'b0000);
      check("lu_stall_count", stall_cycles, 1);
      ex_valid = 1'b1; id_opcode = 8'h82;
      #1 check_ctrl("lu_other_reg", 4'b0000);
      tick;
      check("lu_no_count", stall_cycles, 1);

      // EX carries a load-use partner as well, so the branch must take priority
      $display("[TB] branch squash");
      ex_opcode = 8'h71; ex_valid = 1'b1; ex_branch_taken = 1'b1;
      id_opcode = 8'h81; id_valid = 1'b1;
      #1 check_ctrl("br_cycle1", 4'b0011);
      tick;
      #1 check_ctrl("br_cycle2", 4'b0011);
      tick;
      ex_branch_taken = 1'b0;
      #1 check_ctrl("br_back_in_run", 4'b1101);
      tick;
      check("br_stall_count", stall_cycles, 2);
      ex_valid = 1'b0; id_valid = 1'b0;

      $display("[TB] INA with ack");
      id_opcode = 8'hF3; id_valid = 1'b1;
      #1 check_ctrl("ina_detect", 4'b1101);
      check("ina_req_before", io_bus.io_req, 0);
      tick;
      #1 check_ctrl("ina_wait1", 4'b1101);
      check("ina_req", io_bus.io_req, 1);
      check("ina_we", io_bus.io_we, 0);
      check("ina_port", io_bus.io_port, 3);
      ex_opcode = 8'h04; ex_valid = 1'b1; ex_branch_taken = 1'b1;
      tick;
      #1 check_ctrl("ina_wait2_branch_ignored", 4'b1101);
      tick;
      ex_valid = 1'b0; ex_branch_taken = 1'b0;
      #1 check("ina_req_wait3", io_bus.io_req, 1);
      tick;
      io_bus.io_ack = 1'b1; io_bus.io_rdata = 8'hA5;
      #1 check_ctrl("ina_wait4_ack", 4'b1101);
      tick;
      io_bus.io_rdata = 8'h5A;
      #1 check_ctrl("ina_done", 4'b0000);
      check("ina_req_dropped", io_bus.io_req, 0);
      check("ina_data", in_data, 8'hA5);
      check("ina_ack_beats_timeout", io_timeout, 0);
      tick;
      io_bus.io_ack = 1'b0; id_valid = 1'b0;
      #1 check("ina_late_ack_ignored", in_data, 8'hA5);
      check_ctrl("ina_run", 4'b0000);
      check("ina_stall_count", stall_cycles, 7);

      $display("[TB] OUT timeout");
      id_opcode = 8'hFA; id_valid = 1'b1;
      #1 check_ctrl("out_detect", 4'b1101);
      tick;
      check("out_we", io_bus.io_we, 1);
      check("out_port", io_bus.io_port, 2);
      tick;
      tick;
      check("out_no_early_timeout3", io_timeout, 0);
      tick;
      #1 check_ctrl("out_wait4", 4'b1101);
      check("out_no_early_timeout4", io_timeout, 0);
      tick;
      id_valid = 1'b0;
      #1 check("out_timeout_pulse", io_timeout, 1);
      check("out_req_dropped", io_bus.io_req, 0);
      check("out_data_kept", in_data, 8'hA5);
      check_ctrl("out_done", 4'b0000);
      tick;
      check("out_timeout_one_cycle", io_timeout, 0);
      check("out_stall_count", stall_cycles, 12);

      $display("[TB] reset during IO_WAIT");
      id_opcode = 8'hF3; id_valid = 1'b1;
      tick;
      check("rst_req_before", io_bus.io_req, 1);
      #1 rst_n = 1'b0;
      #1 check("rst_req_async", io_bus.io_req, 0);
      check_ctrl("rst_ctrl_async", 4'b0000);
      check("rst_stall_cleared", stall_cycles, 0);
      check("rst_in_data_cleared", in_data, 0);
      id_valid = 1'b0;
      tick;
      rst_n = 1'b1;
      ex_opcode = 8'h04; ex_valid = 1'b1; ex_branch_taken = 1'b1;
      #1 check_ctrl("rst_state_run", 4'b0011);
      tick;
      tick;
      ex_valid = 1'b0; ex_branch_taken = 1'b0;

      $display("[TB] stall counter saturation");
      ex_opcode = 8'h71; ex_valid = 1'b1; id_opcode = 8'h81; id_valid = 1'b1;
      for (int i = 0; i < 15; i++) tick;
      check("sat_reach_15", stall_cycles, 15);
      for (int i = 0; i < 5; i++) tick;
      check("sat_hold_15", stall_cycles, 15);
      check_ctrl("sat_still_stalling", 4'b1101);
      ex_valid = 1'b0; id_valid = 1'b0;
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
